exe_mem_issue: RTL and testbench
================================

Name: exe_mem_issue

Overview:
- Memory-request half of the EXE pipeline stage: latches decoded load/store info from ID, checks alignment, and issues one data-SRAM request per memory instruction over the req/addr_ok handshake.
- Forwards to the MEM stage a "wait for data_ok" flag plus load-type info.
- Tracks outstanding requests and drops returns that belong to instructions flushed by an exception, so the MEM stage only ever sees a filtered data_ok.

Parameters:
- OUTST_W, 2, width of the outstanding and discard counters (at most 2 requests in flight: one in EXE, one in MEM).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- es_allowin  out  1  EXE can accept from ID
- ds2es_valid  in  1  ID has a valid instruction
- ds_ld_op  in  5  {ld_b, ld_bu, ld_h, ld_hu, ld_w}, one-hot or zero
- ds_st_op  in  3  {st_b, st_h, st_w}, one-hot or zero
- ds_addr  in  32  effective address
- ds_st_data  in  32  store source register
- ds_ex  in  1  instruction already carries an upstream exception
- ms_allowin  in  1  MEM can accept
- es2ms_valid  out  1  EXE hands an instruction to MEM
- es_ld_op  out  5  registered ds_ld_op
- es_addr  out  32  registered address
- es_wait_data_ok  out  1  MEM must wait for data_ok for this instruction
- es_ale  out  1  address-misaligned exception
- ms_ex  in  1  MEM-stage instruction has an exception
- wb_ex  in  1  WB flush
- data_sram_req  out  1  request valid
- data_sram_wr  out  1  1 = store
- data_sram_size  out  2  0 = byte, 1 = half, 2 = word
- data_sram_wstrb  out  4  byte enables
- data_sram_addr  out  32  request address
- data_sram_wdata  out  32  store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  response returned
- ms_data_ok  out  1  filtered data_ok delivered to MEM

Behaviour:
- Reset (async): es_valid, req_sent, outst_cnt, discard_cnt, and all latched fields go to 0. All outputs read 0, except es_allowin = 1.
- Capture: on ds2es_valid & es_allowin, latch ld_op, st_op, addr, st_data, ex_in and clear req_sent.
- es_valid update:
  - wb_ex → 0 (highest priority).
  - else if es_allowin → es_valid <= ds2es_valid.
- Decoded terms:
  - mem_op = |ld_op | |st_op.
  - es_ale = es_valid & ((ld_h|ld_hu|st_h) & addr[0] | (ld_w|st_w) & (addr[1:0] != 0)).
- data_sram_req = es_valid & mem_op & ~es_ale & ~ex_in & ~ms_ex & ~wb_ex & ~req_sent & (discard_cnt == 0).
  - Once asserted, address, size, wr, wstrb and wdata stay stable until addr_ok.
  - The request may be withdrawn only by a flush.
- req_sent sets on data_sram_req & addr_ok and clears on a new capture.
- Ready and handshake:
  - es_ready_go = ~mem_op | es_ale | ex_in | req_sent | (data_sram_req & addr_ok).
  - es_allowin = ~es_valid | es_ready_go & ms_allowin.
  - es2ms_valid = es_valid & es_ready_go & ~wb_ex.
  - es_wait_data_ok = mem_op & (req_sent | data_sram_req & addr_ok).
- Request encoding:
  - data_sram_wr = |st_op.
  - size: byte for b/bu, half for h/hu, word for w.
  - wstrb:
    - st_b: 4'b0001 << addr[1:0].
    - st_h: addr[1] ? 4'b1100 : 4'b0011.
    - st_w: 4'b1111.
    - loads: 4'b0000.
  - wdata: st_b {4{d[7:0]}}; st_h {2{d[15:0]}}; st_w d.
  - data_sram_addr = addr, unmodified.
- outst_cnt: +1 on req & addr_ok, −1 on data_ok; both in the same cycle leaves it unchanged.
- Flush and discard:
  - On wb_ex, discard_cnt <= outst_cnt + (req&addr_ok) − (data_ok ? 1 : 0). The req term is always 0 because req is gated by wb_ex.
  - While discard_cnt != 0, each data_ok decrements discard_cnt and ms_data_ok = 0.
  - Otherwise ms_data_ok = data_sram_data_ok.
  - New requests are blocked until discard_cnt == 0.
- ms_ex gates only req issue; an already-accepted request is never cancelled.
- Counters never exceed 2; reaching 3 is a design error and must be asserted on in simulation.

Test Plan:
- ld_w at 0x1000, addr_ok held low 3 cycles then high: req stays high and stable for 4 cycles → es2ms_valid in cycle 4 with es_wait_data_ok = 1; data_ok in cycle 6 → ms_data_ok = 1.
- st_b at 0x2003 with data 0x000000A5: wstrb = 4'b1000, wdata = 0xA5A5A5A5, size = 0, wr = 1.
- ld_h at 0x3001: es_ale = 1, no req, es2ms_valid next cycle with es_wait_data_ok = 0.
- ld_w accepted in MEM plus ld_w accepted in EXE, then wb_ex: discard_cnt = 2; the next two data_ok give ms_data_ok = 0; a new ld issued in between has req held 0 until the second data_ok.
- ms_ex = 1 while a store sits in EXE: req = 0, wstrb never asserted, es_wait_data_ok = 0.
- resetn dropped mid-handshake with req pending: req, es_valid and counters are 0 immediately (asynchronous); es_allowin = 1.

Source files
------------

// File: rtl/exe_mem_issue.sv
// EXE-stage memory request issue: latches load/store info from ID, checks alignment,
// issues one data-SRAM request per memory op and filters data_ok returns of flushed requests.
module exe_mem_issue #(
  parameter int OUTST_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        es_allowin,
  input  logic        ds2es_valid,
  input  logic [4:0]  ds_ld_op,
  input  logic [2:0]  ds_st_op,
  input  logic [31:0] ds_addr,
  input  logic [31:0] ds_st_data,
  input  logic        ds_ex,
  input  logic        ms_allowin,
  output logic        es2ms_valid,
  output logic [4:0]  es_ld_op,
  output logic [31:0] es_addr,
  output logic        es_wait_data_ok,
  output logic        es_ale,
  input  logic        ms_ex,
  input  logic        wb_ex,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  output logic        ms_data_ok
);

  typedef struct packed {
    logic [4:0]  ld_op;   // {ld_b, ld_bu, ld_h, ld_hu, ld_w}
    logic [2:0]  st_op;   // {st_b, st_h, st_w}
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        ex;
  } es_info_t;

  es_info_t           es_r;
  logic               es_valid;
  logic               req_sent;
  logic [OUTST_W-1:0] outst_cnt;
  logic [OUTST_W-1:0] discard_cnt;

  logic ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w;
  logic mem_op, req_acc, es_ready_go, capture;
  logic [OUTST_W-1:0] outst_nxt;

  assign {ld_b, ld_bu, ld_h, ld_hu, ld_w} = es_r.ld_op;
  assign {st_b, st_h, st_w}               = es_r.st_op;

  assign mem_op = (|es_r.ld_op) | (|es_r.st_op);
  assign es_ale = es_valid & (((ld_h | ld_hu | st_h) & es_r.addr[0]) |
                              ((ld_w | st_w) & (es_r.addr[1:0] != 2'b00)));

  // ms_ex / wb_ex only block issue; an accepted request is never cancelled.
  assign data_sram_req = es_valid & mem_op & ~es_ale & ~es_r.ex & ~ms_ex & ~wb_ex &
                         ~req_sent & (discard_cnt == '0);
  assign req_acc       = data_sram_req & data_sram_addr_ok;

  assign es_ready_go     = ~mem_op | es_ale | es_r.ex | req_sent | req_acc;
  assign es_allowin      = ~es_valid | (es_ready_go & ms_allowin);
  assign es2ms_valid     = es_valid & es_ready_go & ~wb_ex;
  assign es_wait_data_ok = mem_op & (req_sent | req_acc);
  assign capture         = ds2es_valid & es_allowin;

  assign es_ld_op = es_r.ld_op;
  assign es_addr  = es_r.addr;

  assign data_sram_wr   = |es_r.st_op;
  assign data_sram_addr = es_r.addr;

  always_comb begin
    data_sram_size = 2'd0;
    if (ld_h | ld_hu | st_h)   data_sram_size = 2'd1;
    else if (ld_w | st_w)      data_sram_size = 2'd2;
  end

  // Byte enables only show while a request is actually on the bus.
  always_comb begin
    data_sram_wstrb = 4'b0000;
    if (data_sram_req) begin
      if (st_b)      data_sram_wstrb = 4'b0001 << es_r.addr[1:0];
      else if (st_h) data_sram_wstrb = es_r.addr[1] ? 4'b1100 : 4'b0011;
      else if (st_w) data_sram_wstrb = 4'b1111;
    end
  end

  always_comb begin
    data_sram_wdata = 32'd0;
    if (st_b)      data_sram_wdata = {4{es_r.st_data[7:0]}};
    else if (st_h) data_sram_wdata = {2{es_r.st_data[15:0]}};
    else if (st_w) data_sram_wdata = es_r.st_data;
  end

  assign ms_data_ok = data_sram_data_ok & (discard_cnt == '0);
  assign outst_nxt  = outst_cnt + OUTST_W'(req_acc) - OUTST_W'(data_sram_data_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_r        <= '0;
      es_valid    <= 1'b0;
      req_sent    <= 1'b0;
      outst_cnt   <= '0;
      discard_cnt <= '0;
    end else begin
      if (wb_ex)           es_valid <= 1'b0;
      else if (es_allowin) es_valid <= ds2es_valid;

      if (capture) begin
        es_r     <= '{ld_op: ds_ld_op, st_op: ds_st_op, addr: ds_addr,
                      st_data: ds_st_data, ex: ds_ex};
        req_sent <= 1'b0;
      end else if (req_acc) begin
        req_sent <= 1'b1;
      end

      outst_cnt <= outst_nxt;

      // On flush every request still in flight belongs to a dead instruction.
      if (wb_ex)
        discard_cnt <= outst_nxt;
      else if (data_sram_data_ok && discard_cnt != '0)
        discard_cnt <= discard_cnt - 1'b1;
    end
  end

  a_outst_max: assert property (@(posedge clk) disable iff (!resetn)
                                outst_cnt <= OUTST_W'(2));
  a_discard_max: assert property (@(posedge clk) disable iff (!resetn)
                                  discard_cnt <= OUTST_W'(2));

endmodule

// File: tb/tb_exe_mem_issue.sv
// Directed bench for exe_mem_issue: inputs change on negedge, outputs checked 1ns later.
module tb_exe_mem_issue;
  logic        clk = 1'b0;
  logic        resetn;
  logic        es_allowin, ds2es_valid, ds_ex, ms_allowin, es2ms_valid;
  logic [4:0]  ds_ld_op, es_ld_op;
  logic [2:0]  ds_st_op;
  logic [31:0] ds_addr, ds_st_data, es_addr;
  logic        es_wait_data_ok, es_ale, ms_ex, wb_ex;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok, ms_data_ok;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] LD_W = 5'b00001;
  localparam logic [4:0] LD_H = 5'b00100;
  localparam logic [2:0] ST_B = 3'b100;
  localparam logic [2:0] ST_W = 3'b001;

  exe_mem_issue #(.OUTST_W(2)) dut (
    .clk(clk), .resetn(resetn), .es_allowin(es_allowin), .ds2es_valid(ds2es_valid),
    .ds_ld_op(ds_ld_op), .ds_st_op(ds_st_op), .ds_addr(ds_addr), .ds_st_data(ds_st_data),
    .ds_ex(ds_ex), .ms_allowin(ms_allowin), .es2ms_valid(es2ms_valid), .es_ld_op(es_ld_op),
    .es_addr(es_addr), .es_wait_data_ok(es_wait_data_ok), .es_ale(es_ale), .ms_ex(ms_ex),
    .wb_ex(wb_ex), .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .ms_data_ok(ms_data_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pass one posedge, land on the following negedge for driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] ld, input logic [2:0] st,
                       input logic [31:0] a, input logic [31:0] d);
    ds2es_valid = 1'b1; ds_ld_op = ld; ds_st_op = st; ds_addr = a; ds_st_data = d;
  endtask

  task automatic idle_ds();
    ds2es_valid = 1'b0; ds_ld_op = '0; ds_st_op = '0; ds_addr = '0; ds_st_data = '0;
  endtask

  initial begin
    resetn = 1'b0; idle_ds(); ds_ex = 1'b0; ms_allowin = 1'b1; ms_ex = 1'b0; wb_ex = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    #3;
    chk("rst_allowin", 32'(es_allowin), 32'd1);
    chk("rst_req", 32'(data_sram_req), 32'd0);
    chk("rst_es2ms", 32'(es2ms_valid), 32'd0);
    chk("rst_wstrb", 32'(data_sram_wstrb), 32'd0);
    chk("rst_addr", data_sram_addr, 32'd0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;

    // ld_w 0x1000, addr_ok withheld 3 cycles
    issue(LD_W, 3'b000, 32'h1000, 32'h0);
    tick(); idle_ds(); #1;
    chk("ldw_req_c1", 32'(data_sram_req), 32'd1);
    chk("ldw_addr_c1", data_sram_addr, 32'h1000);
    chk("ldw_size", 32'(data_sram_size), 32'd2);
    chk("ldw_wr", 32'(data_sram_wr), 32'd0);
    chk("ldw_es2ms_c1", 32'(es2ms_valid), 32'd0);
    chk("ldw_allowin_c1", 32'(es_allowin), 32'd0);
    tick(); #1;
    chk("ldw_req_c2", 32'(data_sram_req), 32'd1);
    chk("ldw_addr_c2", data_sram_addr, 32'h1000);
    tick(); #1;
    chk("ldw_req_c3", 32'(data_sram_req), 32'd1);
    tick(); data_sram_addr_ok = 1'b1; #1;
    chk("ldw_req_c4", 32'(data_sram_req), 32'd1);
    chk("ldw_es2ms_c4", 32'(es2ms_valid), 32'd1);
    chk("ldw_wait_c4", 32'(es_wait_data_ok), 32'd1);
    chk("ldw_ldop_c4", 32'(es_ld_op), 32'(LD_W));
    tick(); data_sram_addr_ok = 1'b0; #1;
    chk("ldw_req_c5", 32'(data_sram_req), 32'd0);
    chk("ldw_es2ms_c5", 32'(es2ms_valid), 32'd0);
    tick(); data_sram_data_ok = 1'b1; #1;
    chk("ldw_msdok_c6", 32'(ms_data_ok), 32'd1);
    tick(); data_sram_data_ok = 1'b0;

    // st_b 0x2003
    issue(3'b000 == 3'b000 ? 5'b0 : 5'b0, ST_B, 32'h2003, 32'h000000A5);
    tick(); idle_ds(); data_sram_addr_ok = 1'b1; #1;
    chk("stb_req", 32'(data_sram_req), 32'd1);
    chk("stb_wstrb", 32'(data_sram_wstrb), 32'b1000);
    chk("stb_wdata", data_sram_wdata, 32'hA5A5A5A5);
    chk("stb_size", 32'(data_sram_size), 32'd0);
    chk("stb_wr", 32'(data_sram_wr), 32'd1);
    chk("stb_es2ms", 32'(es2ms_valid), 32'd1);
    tick(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; #1;
    chk("stb_msdok", 32'(ms_data_ok), 32'd1);
    tick(); data_sram_data_ok = 1'b0;

    // ld_h 0x3001 misaligned
    issue(LD_H, 3'b000, 32'h3001, 32'h0);
    tick(); idle_ds(); #1;
    chk("ldh_ale", 32'(es_ale), 32'd1);
    chk("ldh_req", 32'(data_sram_req), 32'd0);
    chk("ldh_es2ms", 32'(es2ms_valid), 32'd1);
    chk("ldh_wait", 32'(es_wait_data_ok), 32'd0);
    tick();

    // st_w blocked by ms_ex, then flushed
    issue(5'b0, ST_W, 32'h4000, 32'h12345678); ms_ex = 1'b1;
    tick(); idle_ds(); #1;
    chk("msex_req", 32'(data_sram_req), 32'd0);
    chk("msex_wstrb", 32'(data_sram_wstrb), 32'd0);
    chk("msex_wait", 32'(es_wait_data_ok), 32'd0);
    chk("msex_es2ms", 32'(es2ms_valid), 32'd0);
    tick(); #1;
    chk("msex_wstrb_c2", 32'(data_sram_wstrb), 32'd0);
    chk("msex_req_c2", 32'(data_sram_req), 32'd0);
    tick(); wb_ex = 1'b1; #1;
    chk("msex_flush_es2ms", 32'(es2ms_valid), 32'd0);
    tick(); wb_ex = 1'b0; ms_ex = 1'b0; #1;
    chk("msex_after_allowin", 32'(es_allowin), 32'd1);
    chk("msex_after_req", 32'(data_sram_req), 32'd0);

    // two loads in flight, then flush: both returns discarded
    issue(LD_W, 3'b000, 32'h5000, 32'h0);
    tick(); issue(LD_W, 3'b000, 32'h5004, 32'h0); data_sram_addr_ok = 1'b1; #1;
    chk("dis_a_req", 32'(data_sram_req), 32'd1);
    chk("dis_a_addr", data_sram_addr, 32'h5000);
    chk("dis_a_allowin", 32'(es_allowin), 32'd1);
    tick(); idle_ds(); ms_allowin = 1'b0; #1;
    chk("dis_b_req", 32'(data_sram_req), 32'd1);
    chk("dis_b_addr", data_sram_addr, 32'h5004);
    chk("dis_b_allowin", 32'(es_allowin), 32'd0);
    tick(); data_sram_addr_ok = 1'b0; wb_ex = 1'b1; #1;
    chk("dis_flush_req", 32'(data_sram_req), 32'd0);
    chk("dis_flush_es2ms", 32'(es2ms_valid), 32'd0);
    tick(); wb_ex = 1'b0; ms_allowin = 1'b1; issue(LD_W, 3'b000, 32'h6000, 32'h0); #1;
    chk("dis_c_allowin", 32'(es_allowin), 32'd1);
    tick(); idle_ds(); #1;
    chk("dis_c_req_blk0", 32'(data_sram_req), 32'd0);
    tick(); data_sram_data_ok = 1'b1; #1;
    chk("dis_dok1_ms", 32'(ms_data_ok), 32'd0);
    chk("dis_dok1_req", 32'(data_sram_req), 32'd0);
    tick(); data_sram_data_ok = 1'b0; #1;
    chk("dis_c_req_blk1", 32'(data_sram_req), 32'd0);
    tick(); data_sram_data_ok = 1'b1; #1;
    chk("dis_dok2_ms", 32'(ms_data_ok), 32'd0);
    chk("dis_dok2_req", 32'(data_sram_req), 32'd0);
    tick(); data_sram_data_ok = 1'b0; #1;
    chk("dis_c_req_go", 32'(data_sram_req), 32'd1);
    chk("dis_c_addr", data_sram_addr, 32'h6000);

    // asynchronous reset with the request pending
    #2 resetn = 1'b0; #1;
    chk("arst_req", 32'(data_sram_req), 32'd0);
    chk("arst_es2ms", 32'(es2ms_valid), 32'd0);
    chk("arst_allowin", 32'(es_allowin), 32'd1);
    chk("arst_ldop", 32'(es_ld_op), 32'd0);
    tick(); resetn = 1'b1;
    tick(); #1;
    chk("arst_post_req", 32'(data_sram_req), 32'd0);
    chk("arst_post_allowin", 32'(es_allowin), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected finish before 20000");
    $fatal(1, "timeout");
  end
endmodule
